// File: rtl/stream_pop_n.sv
// Pops N WIDTH-bit elements off sIn into dOut, then forwards the remaining stream tail to sOut.
// Define STREAM_POP_SKID_EN to register the tail path through a 2-entry skid buffer.
module stream_pop_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [WIDTH-1:0]   sIn,
  input  logic               sIn_valid,
  output logic               sIn_ready,
  output logic [WIDTH-1:0]   sOut,
  output logic               sOut_valid,
  input  logic               sOut_ready,
  output logic [N*WIDTH-1:0] dOut
);

  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE,
    PASS
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [N*WIDTH-1:0] dout_q, dout_d;

  logic               pass_open;
  logic               pass_ready;
  logic               take;
  logic [CNT_W-1:0]   slot;
  logic [CNT_W-1:0]   cnt_next;

  assign dOut = dout_q;

  // An activation seen in PASS behaves as the first COLLECT cycle (slot 0).
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dout_d    = dout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sIn_ready = 1'b0;
    take      = 1'b0;
    pass_open = 1'b0;
    slot      = count_q;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      COLLECT: begin
        sIn_ready = 1'b1;
        take      = sIn_valid;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = PASS;
        end
      end
      PASS: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sIn_ready = 1'b1;
          take      = sIn_valid;
          slot      = '0;
          state_d   = COLLECT;
          count_d   = '0;
        end else begin
          pass_open = 1'b1;
          sIn_ready = pass_ready;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    cnt_next = slot + CNT_W'(1);
    if (take) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (slot == CNT_W'(k)) begin
          dout_d[k*WIDTH +: WIDTH] = sIn;
        end
      end
      count_d = cnt_next;
      state_d = (cnt_next == CNT_W'(N)) ? DONE : COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

`ifdef STREAM_POP_SKID_EN
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             push, pop, flush;

  // Readiness comes from occupancy alone, so sOut_ready never reaches sIn_ready.
  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    pass_ready = (occ_q != 2'd2);
    push       = pass_open && sIn_valid && pass_ready;
    pop        = (occ_q != 2'd0) && sOut_ready;
    flush      = (state_q == PASS) && in_valid;
    sOut       = mem_q[rptr_q];
    sOut_valid = (occ_q != 2'd0);

    if (flush) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      occ_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = sIn;
        wptr_d        = ~wptr_q;
      end
      if (pop) begin
        rptr_d = ~rptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end
`else
  always_comb begin
    pass_ready = sOut_ready;
    sOut       = sIn;
    sOut_valid = pass_open && sIn_valid;
  end
`endif

endmodule

// File: tb/tb_stream_pop_n.sv
// Directed bench for stream_pop_n: four instances cover N=2, N=3 (stalls), N=16 and N=1.
// Tail expectations shift by one cycle when STREAM_POP_SKID_EN is defined.
module tb_stream_pop_n;

`ifdef STREAM_POP_SKID_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic        a_sin_valid, a_sin_ready, a_sout_valid, a_sout_ready;
  logic [7:0]  a_sin, a_sout;
  logic [15:0] a_dout;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_sin_valid, b_sin_ready, b_sout_valid, b_sout_ready;
  logic [7:0]  b_sin, b_sout;
  logic [23:0] b_dout;

  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic         c_sin_valid, c_sin_ready, c_sout_valid, c_sout_ready;
  logic [15:0]  c_sin, c_sout;
  logic [255:0] c_dout;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic        d_sin_valid, d_sin_ready, d_sout_valid, d_sout_ready;
  logic [15:0] d_sin, d_sout;
  logic [15:0] d_dout;

  logic [7:0] b_vals  [5] = '{8'd10, 8'd99, 8'd11, 8'd99, 8'd12};
  logic       b_valid [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  stream_pop_n #(.WIDTH(8), .N(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .sIn(a_sin),
    .sIn_valid(a_sin_valid), .sIn_ready(a_sin_ready), .sOut(a_sout),
    .sOut_valid(a_sout_valid), .sOut_ready(a_sout_ready), .dOut(a_dout)
  );

  stream_pop_n #(.WIDTH(8), .N(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .sIn(b_sin),
    .sIn_valid(b_sin_valid), .sIn_ready(b_sin_ready), .sOut(b_sout),
    .sOut_valid(b_sout_valid), .sOut_ready(b_sout_ready), .dOut(b_dout)
  );

  stream_pop_n #(.WIDTH(16), .N(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .sIn(c_sin),
    .sIn_valid(c_sin_valid), .sIn_ready(c_sin_ready), .sOut(c_sout),
    .sOut_valid(c_sout_valid), .sOut_ready(c_sout_ready), .dOut(c_dout)
  );

  stream_pop_n #(.WIDTH(16), .N(1)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .sIn(d_sin),
    .sIn_valid(d_sin_valid), .sIn_ready(d_sin_ready), .sOut(d_sout),
    .sOut_valid(d_sout_valid), .sOut_ready(d_sout_ready), .dOut(d_dout)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned sv;
    int unsigned next_tail;

    rst = 1'b1;
    {a_in_valid, a_out_ready, a_sin_valid, a_sout_ready} = '0;
    {b_in_valid, b_out_ready, b_sin_valid, b_sout_ready} = '0;
    {c_in_valid, c_out_ready, c_sin_valid, c_sout_ready} = '0;
    {d_in_valid, d_out_ready, d_sin_valid, d_sout_ready} = '0;
    a_sin = '0; b_sin = '0; c_sin = '0; d_sin = '0;

    repeat (2) cyc();
    #1;
    chk("rst_in_ready",   a_in_ready,   1'b1);
    chk("rst_out_valid",  a_out_valid,  1'b0);
    chk("rst_sout_valid", a_sout_valid, 1'b0);
    chk("rst_sin_ready",  a_sin_ready,  1'b0);
    chk("rst_dout",       a_dout,       16'h0000);
    rst = 1'b0;

    // Basic pop, N=2
    a_sin_valid = 1'b1; a_out_ready = 1'b1; a_sout_ready = 1'b1;
    cyc(); a_in_valid = 1'b1; a_sin = 8'd0; #1;
    chk("basic_idle_in_ready", a_in_ready, 1'b1);
    chk("basic_idle_sin_ready", a_sin_ready, 1'b0);
    cyc(); a_in_valid = 1'b0; a_sin = 8'd1; #1;
    chk("basic_col_sin_ready", a_sin_ready, 1'b1);
    chk("basic_col_in_ready", a_in_ready, 1'b0);
    chk("basic_col_out_valid0", a_out_valid, 1'b0);
    cyc(); a_sin = 8'd2; #1;
    chk("basic_col_out_valid1", a_out_valid, 1'b0);
    cyc(); a_sin = 8'd3; #1;
    chk("basic_done_out_valid", a_out_valid, 1'b1);
    chk("basic_done_dout", a_dout, 16'h0201);
    chk("basic_done_sin_ready", a_sin_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(); a_sin = 8'(3 + i); #1;
      if (i == 0) begin
        chk("basic_pass_out_valid", a_out_valid, 1'b0);
        chk("basic_pass_in_ready", a_in_ready, 1'b1);
      end
      chk("basic_tail_valid", a_sout_valid, logic'(i >= LAT));
      if (i >= LAT) chk("basic_tail_data", a_sout, 8'(3 + i - LAT));
    end

    // Back-pressure on the tail path; nothing may be lost
    next_tail = 32'(7 - LAT);
    sv = 7;
    for (int j = 0; j < 6; j++) begin
      cyc(); a_sin = 8'(sv); a_sout_ready = (j >= 3); #1;
      if (j == 2) chk("bp_sin_ready", a_sin_ready, 1'b0);
      if (a_sout_valid && a_sout_ready) begin
        chk("bp_tail", a_sout, 8'(next_tail));
        next_tail++;
      end
      if (a_sin_valid && a_sin_ready) sv++;
    end
    chk("bp_tail_count", next_tail, 32'(10 - LAT));

    // Re-activation in PASS, then back-pressure in DONE
    cyc(); a_in_valid = 1'b1; a_sin = 8'd7; a_sout_ready = 1'b1; #1;
    chk("react_sin_ready", a_sin_ready, 1'b1);
`ifndef STREAM_POP_SKID_EN
    chk("react_sout_valid", a_sout_valid, 1'b0);
`endif
    cyc(); a_in_valid = 1'b0; a_sin = 8'd8; #1;
    chk("react_col_in_ready", a_in_ready, 1'b0);
    chk("react_col_out_valid", a_out_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_sin = 8'd9; #1;
      chk("hold_out_valid", a_out_valid, 1'b1);
      chk("hold_dout", a_dout, 16'h0807);
      chk("hold_sin_ready", a_sin_ready, 1'b0);
      chk("hold_sout_valid", a_sout_valid, 1'b0);
    end
    cyc(); a_in_valid = 1'b0; a_out_ready = 1'b1; #1;
    chk("release_out_valid", a_out_valid, 1'b1);
    cyc(); #1;
    chk("release_pass_out_valid", a_out_valid, 1'b0);
    chk("release_pass_in_ready", a_in_ready, 1'b1);

    // Reset mid-COLLECT after one element
    cyc(); a_in_valid = 1'b1; a_sin = 8'h30; #1;
    cyc(); a_in_valid = 1'b0; a_sin = 8'h31; rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    chk("mrst_in_ready", a_in_ready, 1'b1);
    chk("mrst_out_valid", a_out_valid, 1'b0);
    chk("mrst_dout", a_dout, 16'h0000);
    chk("mrst_sin_ready", a_sin_ready, 1'b0);
    cyc(); a_in_valid = 1'b1; a_sin = 8'd19; #1;
    cyc(); a_in_valid = 1'b0; a_sin = 8'd20; #1;
    cyc(); a_sin = 8'd21; #1;
    cyc(); a_sin = 8'd22; #1;
    chk("mrst_fresh_out_valid", a_out_valid, 1'b1);
    chk("mrst_fresh_dout", a_dout, 16'h1514);

    // Stalled stream, N=3
    b_out_ready = 1'b1; b_sout_ready = 1'b1;
    cyc(); b_in_valid = 1'b1; b_sin_valid = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      cyc(); b_in_valid = 1'b0; b_sin_valid = b_valid[i]; b_sin = b_vals[i]; #1;
      chk("stall_out_valid", b_out_valid, 1'b0);
      chk("stall_sin_ready", b_sin_ready, 1'b1);
    end
    cyc(); b_sin_valid = 1'b0; #1;
    chk("stall_done_out_valid", b_out_valid, 1'b1);
    chk("stall_done_dout", b_dout, 24'h0C0B0A);

    // WIDTH=16, N=16
    c_out_ready = 1'b1; c_sout_ready = 1'b1; c_sin_valid = 1'b1;
    cyc(); c_in_valid = 1'b1; c_sin = 16'h0FFF; #1;
    for (int i = 0; i < 16; i++) begin
      cyc(); c_in_valid = 1'b0; c_sin = 16'(16'h1000 + i); #1;
      if (i == 15) chk("n16_last_out_valid", c_out_valid, 1'b0);
    end
    cyc(); c_sin = 16'h1010; #1;
    chk("n16_out_valid", c_out_valid, 1'b1);
    for (int k = 0; k < 16; k++) begin
      chk("n16_slot", c_dout[k*16 +: 16], 16'(16'h1000 + k));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); c_sin = 16'(16'h1010 + i); #1;
      chk("n16_tail_valid", c_sout_valid, logic'(i >= LAT));
      if (i >= LAT) chk("n16_tail_data", c_sout, 16'(16'h1010 + i - LAT));
    end

    // WIDTH=16, N=1
    d_out_ready = 1'b1; d_sout_ready = 1'b1; d_sin_valid = 1'b1;
    cyc(); d_in_valid = 1'b1; d_sin = 16'h0FFF; #1;
    cyc(); d_in_valid = 1'b0; d_sin = 16'h1000; #1;
    chk("n1_col_sin_ready", d_sin_ready, 1'b1);
    chk("n1_col_out_valid", d_out_valid, 1'b0);
    cyc(); d_sin = 16'h1001; #1;
    chk("n1_done_out_valid", d_out_valid, 1'b1);
    chk("n1_done_dout", d_dout, 16'h1000);
    for (int i = 0; i < 3; i++) begin
      cyc(); d_sin = 16'(16'h1001 + i); #1;
      chk("n1_tail_valid", d_sout_valid, logic'(i >= LAT));
      if (i >= LAT) chk("n1_tail_data", d_sout, 16'(16'h1001 + i - LAT));
    end
    cyc(); d_in_valid = 1'b1; d_sin = 16'h2000; #1;
    cyc(); d_in_valid = 1'b0; d_sin = 16'h2001; #1;
    chk("n1_react_out_valid", d_out_valid, 1'b1);
    chk("n1_react_dout", d_dout, 16'h2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_pop_n.md
Name: stream_pop_n

Overview:
- Parametrised successor to the fixed two-element stream pop primitive.
- Pops N consecutive WIDTH-bit elements off an input stream and presents them in parallel as N int outputs, under the sync handshake (in_valid/in_ready, out_valid/out_ready).
- After the pop completes, it forwards the remaining stream tail to sOut.
- Used wherever compiled code destructures the head of a list/stream, and chains with other sync primitives.

Parameters:
- WIDTH, 8, bit width of each stream element and each int output (`intN`).
- N, 2, number of elements popped per activation; legal range 1..16.
- CNT_W, $clog2(N+1), width of the element counter; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  activation request; accepted when in_valid && in_ready.
- in_ready  out  1  high in IDLE and PASS states.
- out_valid  out  1  popped values valid (DONE state).
- out_ready  in  1  consumer accepts dOut when out_valid && out_ready.
- sIn  in  WIDTH  input stream data.
- sIn_valid  in  1  input stream element valid.
- sIn_ready  out  1  element consumed when sIn_valid && sIn_ready.
- sOut  out  WIDTH  tail stream data.
- sOut_valid  out  1  tail element valid.
- sOut_ready  in  1  downstream accepts tail element.
- dOut  out  N*WIDTH  popped elements; element k in bits [k*WIDTH +: WIDTH]; element 0 is the first popped.

Behaviour:
- Reset (rst high at posedge): state=IDLE, count=0, dOut=0, out_valid=0, sOut_valid=0, sIn_ready=0, in_ready=1. Reset mid-operation discards partially collected elements and any held tail element.
- FSM states:
  - IDLE: in_ready=1, sIn_ready=0. Activation → COLLECT, count=0.
  - COLLECT: in_ready=0, sIn_ready=1, out_valid=0, sOut_valid=0.
    - Each accepted element is written to slot count, then count increments.
    - When the element that makes count==N is accepted → DONE on the next cycle.
    - Gaps in sIn_valid stall the count without losing data.
  - DONE: out_valid=1, dOut stable, sIn_ready=0, in_ready=0. Stays until out_ready is sampled high → PASS. With out_ready held high, out_valid is high for exactly one cycle.
  - PASS: forwards tail, sOut=sIn, sOut_valid=sIn_valid, sIn_ready=sOut_ready (combinational). in_ready=1, dOut holds last values. Activation in PASS → COLLECT, count=0; that cycle's sIn element is consumed by COLLECT, not forwarded: sIn_ready=1, sOut_valid=0 that cycle.
- Latency (N=2, stream always valid, in_valid at cycle 0): elements taken at cycles 1..N, out_valid at cycle N+1, tail forwarding from cycle N+2 if out_ready=1.
- Counter: CNT_W bits; never exceeds N; resets to 0 on each activation.
- in_valid is ignored in COLLECT and DONE. A request must be held until in_ready.
- dOut is updated only in COLLECT; never glitches while out_valid=1.

Optional Feature:
- Macro STREAM_POP_SKID_EN.
- Defined:
  - PASS path goes through a 2-entry skid buffer; sOut/sOut_valid are registered (+1 cycle tail latency).
  - sIn_ready depends only on buffer occupancy, with no combinational path from sOut_ready.
  - On activation in PASS or on rst, the buffer is flushed: sOut_valid=0 next cycle, buffered elements dropped.
- Undefined: combinational pass-through as described in Behaviour.

Test Plan:
- Basic pop (N=2, WIDTH=8): sIn counts 1,2,3… every cycle, sIn_valid=1, pulse in_valid, out_ready=1 → dOut={8'd2,8'd1}, out_valid 1 cycle, then sOut=3,4,5 with sOut_valid=1.
- Stalled stream: N=3, sIn_valid toggles 1,0,1,0,1 carrying 10,11,12 → count pauses on gaps; dOut={12,11,10}; out_valid asserts only after the third accepted element.
- Back-pressure: out_ready=0 for 4 cycles in DONE → out_valid held, dOut unchanged, sIn_ready=0. Then out_ready=1 → PASS next cycle. Then sOut_ready=0 in PASS → sIn_ready=0, no elements lost.
- Re-activation in PASS: in_valid during PASS with sIn=7 → 7 is the first popped element (slot 0), not seen on sOut; the next out_valid shows element 0 = 7.
- Reset mid-COLLECT: rst after 1 of 2 elements → state IDLE, out_valid=0, dOut=0. A fresh activation with stream 20,21 → dOut={21,20}.
- Width/depth sweep: WIDTH=16, N=1 and N=16 with stream 0x1000+i → each dOut slot k equals 0x1000+k. Repeat with STREAM_POP_SKID_EN defined: the tail appears 1 cycle later with an identical sequence.
